// File: rtl/mcycle_core.sv
// Multi-cycle RISC-V integer core (XLEN 32/64) with a FETCH/EXEC/MEM/HALT sequencer.
// Define MCORE_BRANCH_EXT_EN to also decode blt/bge/bltu/bgeu.
module mcycle_core #(
  parameter int unsigned XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_wstrb,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [XLEN-1:0]   pc,
  output logic              retire,
  output logic              halt,
  output logic              halt_trap,
  output logic [XLEN-1:0]   halt_code
);

  localparam int unsigned    NB          = XLEN / 8;
  localparam logic [XLEN-1:0] LP_RESET_PC = RESET_PC[XLEN-1:0];

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_rf [32];
  logic            r_halt;
  logic            r_trap;
  logic [XLEN-1:0] r_code;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1_idx;
  logic [4:0]      w_rs2_idx;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;

  logic signed [31:0] w_imm_i32;
  logic signed [31:0] w_imm_s32;
  logic signed [31:0] w_imm_b32;
  logic signed [31:0] w_imm_u32;
  logic signed [31:0] w_imm_j32;
  logic signed [31:0] w_ld_word;
  logic [XLEN-1:0]    w_imm_i;
  logic [XLEN-1:0]    w_imm_s;
  logic [XLEN-1:0]    w_imm_b;
  logic [XLEN-1:0]    w_imm_u;
  logic [XLEN-1:0]    w_imm_j;

  logic            w_legal;
  logic            w_wb_en;
  logic [XLEN-1:0] w_wb_data;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_next_pc;
  logic            w_taken;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_dword;
  logic            w_is_ebreak;
  logic            w_is_mem;
  logic [XLEN-1:0] w_mem_addr;
  logic            w_misaligned;
  logic [XLEN-1:0] w_st_data;
  logic [NB-1:0]   w_st_strb;
  logic [XLEN-1:0] w_ld_data;
  logic            w_rf_we;
  logic [XLEN-1:0] w_rf_wdata;
  logic            w_dreq;

  assign w_opcode  = r_instr[6:0];
  assign w_rd      = r_instr[11:7];
  assign w_funct3  = r_instr[14:12];
  assign w_rs1_idx = r_instr[19:15];
  assign w_rs2_idx = r_instr[24:20];
  assign w_funct7  = r_instr[31:25];

  assign w_rs1 = (w_rs1_idx == 5'd0) ? '0 : r_rf[w_rs1_idx];
  assign w_rs2 = (w_rs2_idx == 5'd0) ? '0 : r_rf[w_rs2_idx];

  // Immediates are assembled at 32 bits as signed words, then sign-extended to XLEN.
  assign w_imm_i32 = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_imm_s32 = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
  assign w_imm_b32 = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                      r_instr[11:8], 1'b0};
  assign w_imm_u32 = {r_instr[31:12], 12'b0};
  assign w_imm_j32 = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20],
                      r_instr[30:21], 1'b0};
  assign w_imm_i   = XLEN'(w_imm_i32);
  assign w_imm_s   = XLEN'(w_imm_s32);
  assign w_imm_b   = XLEN'(w_imm_b32);
  assign w_imm_u   = XLEN'(w_imm_u32);
  assign w_imm_j   = XLEN'(w_imm_j32);

  assign w_pc4 = r_pc + XLEN'(4);

  always_comb begin
    w_legal     = 1'b0;
    w_wb_en     = 1'b0;
    w_wb_data   = '0;
    w_next_pc   = w_pc4;
    w_taken     = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_dword  = 1'b0;
    w_is_ebreak = 1'b0;
    case (w_opcode)
      OP_IMM: begin
        if (w_funct3 == 3'b000) begin
          w_legal   = 1'b1;
          w_wb_en   = 1'b1;
          w_wb_data = w_rs1 + w_imm_i;
        end else if (w_funct3 == 3'b011) begin
          w_legal   = 1'b1;
          w_wb_en   = 1'b1;
          w_wb_data = {{(XLEN-1){1'b0}}, (w_rs1 < w_imm_i)};
        end
      end
      OP_REG: begin
        if (w_funct3 == 3'b000 && w_funct7 == 7'b0000000) begin
          w_legal   = 1'b1;
          w_wb_en   = 1'b1;
          w_wb_data = w_rs1 + w_rs2;
        end else if (w_funct3 == 3'b000 && w_funct7 == 7'b0100000) begin
          w_legal   = 1'b1;
          w_wb_en   = 1'b1;
          w_wb_data = w_rs1 - w_rs2;
        end
      end
      OP_LUI: begin
        w_legal   = 1'b1;
        w_wb_en   = 1'b1;
        w_wb_data = w_imm_u;
      end
      OP_AUIPC: begin
        w_legal   = 1'b1;
        w_wb_en   = 1'b1;
        w_wb_data = r_pc + w_imm_u;
      end
      OP_JAL: begin
        w_legal   = 1'b1;
        w_wb_en   = 1'b1;
        w_wb_data = w_pc4;
        w_next_pc = r_pc + w_imm_j;
      end
      OP_JALR: begin
        if (w_funct3 == 3'b000) begin
          w_legal   = 1'b1;
          w_wb_en   = 1'b1;
          w_wb_data = w_pc4;
          w_next_pc = (w_rs1 + w_imm_i) & ~XLEN'(1);
        end
      end
      OP_BRANCH: begin
        w_legal = 1'b1;
        case (w_funct3)
          3'b000: w_taken = (w_rs1 == w_rs2);
          3'b001: w_taken = (w_rs1 != w_rs2);
`ifdef MCORE_BRANCH_EXT_EN
          3'b100: w_taken = ($signed(w_rs1) < $signed(w_rs2));
          3'b101: w_taken = ($signed(w_rs1) >= $signed(w_rs2));
          3'b110: w_taken = (w_rs1 < w_rs2);
          3'b111: w_taken = (w_rs1 >= w_rs2);
`endif
          default: w_legal = 1'b0;
        endcase
        if (w_taken) w_next_pc = r_pc + w_imm_b;
      end
      OP_LOAD: begin
        if (w_funct3 == 3'b010) begin
          w_legal   = 1'b1;
          w_is_load = 1'b1;
        end else if (w_funct3 == 3'b011 && XLEN == 64) begin
          w_legal    = 1'b1;
          w_is_load  = 1'b1;
          w_is_dword = 1'b1;
        end
      end
      OP_STORE: begin
        if (w_funct3 == 3'b010) begin
          w_legal    = 1'b1;
          w_is_store = 1'b1;
        end else if (w_funct3 == 3'b011 && XLEN == 64) begin
          w_legal    = 1'b1;
          w_is_store = 1'b1;
          w_is_dword = 1'b1;
        end
      end
      OP_SYSTEM: begin
        if (r_instr == 32'h0010_0073) begin
          w_legal     = 1'b1;
          w_is_ebreak = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign w_is_mem     = w_is_load | w_is_store;
  assign w_mem_addr   = w_rs1 + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);
  assign w_misaligned = w_is_dword ? (w_mem_addr[2:0] != 3'b000) : (w_mem_addr[1:0] != 2'b00);

  // A word store replicates rs2[31:0] into every 32-bit half; the strobes pick the half.
  always_comb begin
    w_st_data = '0;
    w_st_strb = '0;
    for (int i = 0; i < int'(NB); i++) begin
      if (w_is_dword) begin
        w_st_data[8*i +: 8] = w_rs2[8*i +: 8];
        w_st_strb[i]        = 1'b1;
      end else begin
        w_st_data[8*i +: 8] = w_rs2[8*(i%4) +: 8];
        w_st_strb[i]        = (XLEN == 32) || ((i / 4) == int'(w_mem_addr[2]));
      end
    end
  end

  assign w_ld_word = dmem_rdata[31:0];
  assign w_ld_data = w_is_dword ? dmem_rdata : XLEN'(w_ld_word);

  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_wdata = w_wb_data;
    if (r_state == S_EXEC && w_wb_en) begin
      w_rf_we = 1'b1;
    end else if (r_state == S_MEM && dmem_ready && w_is_load) begin
      w_rf_we    = 1'b1;
      w_rf_wdata = w_ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= LP_RESET_PC;
      r_instr <= '0;
      r_halt  <= 1'b0;
      r_trap  <= 1'b0;
      r_code  <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!w_legal || (w_is_mem && w_misaligned)) begin
            r_halt  <= 1'b1;
            r_trap  <= 1'b1;
            r_state <= S_HALT;
          end else if (w_is_ebreak) begin
            r_halt  <= 1'b1;
            r_code  <= r_rf[10];
            r_state <= S_HALT;
          end else if (w_is_mem) begin
            r_state <= S_MEM;
          end else begin
            r_pc    <= w_next_pc;
            r_state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            r_pc    <= w_pc4;
            r_state <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // Register file is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_rf_we && (w_rd != 5'd0)) r_rf[w_rd] <= w_rf_wdata;
  end

  assign w_dreq     = rst_n && (r_state == S_MEM);
  assign imem_req   = rst_n && (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = w_dreq;
  assign dmem_we    = w_dreq && w_is_store;
  assign dmem_addr  = w_dreq ? w_mem_addr : '0;
  assign dmem_wdata = (w_dreq && w_is_store) ? w_st_data : '0;
  assign dmem_wstrb = (w_dreq && w_is_store) ? w_st_strb : '0;
  assign retire     = rst_n && (((r_state == S_EXEC) && w_legal && !w_is_mem) ||
                                ((r_state == S_MEM) && dmem_ready));
  assign pc         = r_pc;
  assign halt       = r_halt;
  assign halt_trap  = r_trap;
  assign halt_code  = r_code;

endmodule

// File: doc/mcycle_core.md
# mcycle_core

Multi-cycle RISC-V integer core, parametrised in XLEN (32/64), successor to the single-cycle execution core. Fetches over a request/ready instruction port and executes a small integer subset through a FETCH/EXEC/MEM state machine. Loads and stores go over a separate request/ready data port. Sits between the simulation harness (DPI memory model, halt detection) and the same physical-memory map, with reset PC 0x8000_0000.

## Interface
Parameters:
- XLEN, 64, datapath/register width; legal values 32 or 64.
- RESET_PC, 'h8000_0000, PC loaded on reset, zero-extended to XLEN.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address; always equals pc.
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  XLEN  byte address (rs1 + imm).
- dmem_wdata  out  XLEN  store data, placed at the byte lanes selected by dmem_wstrb.
- dmem_wstrb  out  XLEN/8  byte-lane write enables.
- dmem_ready  in  1  access complete; dmem_rdata valid this cycle.
- dmem_rdata  in  XLEN  load data (aligned XLEN word).
- pc  out  XLEN  current architectural PC.
- retire  out  1  one-cycle pulse when an instruction commits.
- halt  out  1  core stopped; sticky until reset.
- halt_trap  out  1  halt caused by an illegal or misaligned instruction rather than ebreak.
- halt_code  out  XLEN  value of x10 at ebreak; 0 on trap.

## Operation
- Instructions: addi, sltiu, add, sub, lui, auipc, jal, jalr, beq, bne, lw, sw, ebreak. ld and sd are supported only when XLEN=64.
- All other encodings are illegal and halt the core with halt_trap=1.
- Register file: 32 x XLEN, internal. x0 reads 0 and writes to it are ignored.
- Arithmetic is modulo 2^XLEN.
- sltiu compares unsigned against the sign-extended immediate.
- lw sign-extends bits 31:0 to XLEN. At XLEN=32, lw returns dmem_rdata unchanged.
- jalr target = (rs1 + imm) with bit 0 cleared. rd is written with pc + 4, and the target is computed from the old rs1 value when rd = rs1.
- Misaligned access halts with halt_trap=1 and no bus request:
  - lw/sw with addr[1:0] != 0.
  - ld/sd with addr[2:0] != 0.
- Store lanes:
  - sw at XLEN=64: wstrb = 0x0F or 0xF0 by addr[2], with data replicated in both halves.
  - sd: wstrb = 0xFF.
  - sw at XLEN=32: wstrb = 0xF.
- State machine: FETCH, EXEC, MEM, HALT.
  - FETCH: imem_req=1. Latch the instruction and go to EXEC on imem_ready.
  - EXEC: decode and execute.
    - ALU/branch/jump: write rd, update pc, pulse retire, go to FETCH.
    - Load/store: go to MEM, or HALT on misalignment.
    - ebreak: go to HALT, latching halt_code = x10. retire pulses.
    - Illegal: go to HALT. retire does not pulse.
  - MEM: dmem_req=1. On dmem_ready: write rd (loads), pc += 4, pulse retire, go to FETCH.
  - HALT: terminal; all requests 0; pc frozen at the halting instruction.

## Timing
- Reset (rst_n=0 at edge): state=FETCH, pc=RESET_PC, and every output 0 except pc and imem_addr. The register file is not cleared.
- First cycle with rst_n=1: imem_req=1.
- Request rules:
  - imem_req/dmem_req and all address/data/strobe outputs are held stable from assertion until the cycle ready is sampled high.
  - Ready while req=0 is ignored.
  - Ready in the same cycle as req completes the access, with zero wait.
- Latency with zero-wait memory:
  - ALU, branch and jump: 2 cycles (FETCH, EXEC).
  - Load/store: 3 cycles.
- Each wait cycle adds 1.
- retire is asserted in the EXEC or MEM cycle that commits. New pc and rd values are visible the following cycle.
- Reset asserted mid-access: the request drops on the next cycle and the pending access is abandoned. The memory model must tolerate this.

## Configuration
- MCORE_BRANCH_EXT_EN defined: blt, bge, bltu and bgeu are decoded (funct3 100/101/110/111), with signed/unsigned XLEN compares and the same 2-cycle timing.
- MCORE_BRANCH_EXT_EN undefined: those encodings are illegal and halt with halt_trap=1.

## Test plan
- Reset then zero-wait memory, program addi x10,x0,5; ebreak -> imem_addr 0x80000000 then 0x80000004; halt=1, halt_code=5, halt_trap=0, retire pulses 2.
- addi x1,x0,-1; sltiu x2,x1,1; add x3,x1,x1 (XLEN=64) -> x2=0, x3=0xFFFF_FFFF_FFFF_FFFE.
- sw x5 to 0x80001004 with x5=0x1234_5678 (XLEN=64), dmem_ready delayed 3 cycles -> dmem_wstrb=0xF0, address/data stable 4 cycles, retire once.
- lw from 0x80001000 returning rdata low word 0x8000_0000 -> rd=0xFFFF_FFFF_8000_0000.
- bne taken with offset -8 at pc 0x80000010 -> next fetch 0x80000008; jalr x1,0(x1) with x1=0x80000021 -> pc 0x80000020, x1=old pc+4.
- Encoding 0x0000_0000 -> halt=1, halt_trap=1, no retire. lw at addr 0x...2 -> halt_trap=1, dmem_req never asserted.
